// File: rtl/seg_to_num.sv
// Recovers a step index from three 7-segment digit patterns: a stability filter accepts a
// triplet once, it is decoded and mapped to a step, and a tracker locks onto the 0..5 cycle.
module seg_to_num #(
  parameter int unsigned STABLE_CNT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic [6:0]  seg3,
  input  logic [6:0]  seg2,
  input  logic [6:0]  seg1,
  output logic [31:0] num,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic        valid,
  output logic        locked,
  output logic        err,
  output logic        seq_err,
  output logic        dash
);

  localparam logic [3:0] StableCnt = 4'(STABLE_CNT);

  typedef enum logic [1:0] {StUnlocked, StCandidate, StLocked} state_e;

  function automatic logic [3:0] decode(input logic [6:0] seg);
    logic [3:0] d;
    case (seg)
      7'b1000000: d = 4'h0;
      7'b1111001: d = 4'h1;
      7'b0100100: d = 4'h2;
      7'b0110000: d = 4'h3;
      7'b0011001: d = 4'h4;
      7'b0010010: d = 4'h5;
      7'b0000010: d = 4'h6;
      7'b1111000: d = 4'h7;
      7'b0000000: d = 4'h8;
      7'b0010000: d = 4'h9;
      7'b0111111: d = 4'hE;
      default:    d = 4'hF;
    endcase
    return d;
  endfunction

  state_e      state_q, state_d;
  logic [20:0] trip_q, trip_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  pstep_q, pstep_d;
  logic [31:0] num_q, num_d;
  logic [11:0] digits_q, digits_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        seq_err_q, seq_err_d;
  logic        dash_q, dash_d;

  logic [20:0] triplet;
  logic [11:0] digits;
  logic        same;
  logic [3:0]  cnt_next;
  logic        accept;
  logic        mapped;
  logic [2:0]  step;
  logic [2:0]  exp_step;

  assign triplet  = {seg3, seg2, seg1};
  assign digits   = {decode(seg3), decode(seg2), decode(seg1)};
  assign same     = (triplet == trip_q);
  assign cnt_next = !same ? 4'd1 : (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
  // Saturation must not re-accept a triplet that has already reached the threshold.
  assign accept   = sample && (cnt_next == StableCnt) && !(same && (cnt_q == StableCnt));
  assign exp_step = (pstep_q == 3'd5) ? 3'd0 : pstep_q + 3'd1;

  always_comb begin
    mapped = 1'b1;
    step   = 3'd0;
    case (digits)
      12'h000: step = 3'd0;
      12'h003: step = 3'd1;
      12'h032: step = 3'd2;
      12'h321: step = 3'd3;
      12'h210: step = 3'd4;
      12'h100: step = 3'd5;
      12'hEEE: step = 3'd6;
      default: mapped = 1'b0;
    endcase
  end

  always_comb begin
    trip_d    = trip_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    pstep_d   = pstep_q;
    num_d     = num_q;
    digits_d  = digits_q;
    valid_d   = valid_q;
    dash_d    = dash_q;
    err_d     = 1'b0;
    seq_err_d = 1'b0;
    if (sample) begin
      trip_d = triplet;
      cnt_d  = cnt_next;
    end
    if (accept) begin
      digits_d = digits;
      valid_d  = 1'b1;
      if (!mapped) begin
        err_d   = 1'b1;
        dash_d  = 1'b0;
        state_d = StUnlocked;
      end else begin
        num_d  = {29'd0, step};
        dash_d = (step == 3'd6);
        if (step == 3'd6) begin
          seq_err_d = (state_q == StLocked);
          state_d   = StUnlocked;
        end else begin
          pstep_d = step;
          case (state_q)
            StUnlocked:  state_d = StCandidate;
            StCandidate: state_d = (step == exp_step) ? StLocked : StCandidate;
            StLocked: begin
              if (step != exp_step) begin
                seq_err_d = 1'b1;
                state_d   = StCandidate;
              end
            end
            default:     state_d = StUnlocked;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trip_q    <= '1;
      cnt_q     <= 4'd0;
      state_q   <= StUnlocked;
      pstep_q   <= 3'd0;
      num_q     <= 32'd0;
      digits_q  <= 12'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      seq_err_q <= 1'b0;
      dash_q    <= 1'b0;
    end else begin
      trip_q    <= trip_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      pstep_q   <= pstep_d;
      num_q     <= num_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      seq_err_q <= seq_err_d;
      dash_q    <= dash_d;
    end
  end

  assign num     = num_q;
  assign digit3  = digits_q[11:8];
  assign digit2  = digits_q[7:4];
  assign digit1  = digits_q[3:0];
  assign valid   = valid_q;
  assign locked  = (state_q == StLocked);
  assign err     = err_q;
  assign seq_err = seq_err_q;
  assign dash    = dash_q;

endmodule

// File: tb/tb_seg_to_num.sv
// Bench for seg_to_num: directed scenarios plus randomized traffic against a run-length /
// step-table reference model.
module tb_seg_to_num;

  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample = 1'b0;
  logic [6:0]  seg3 = '1, seg2 = '1, seg1 = '1;
  logic [31:0] num;
  logic [3:0]  digit3, digit2, digit1;
  logic        valid, locked, err, seq_err, dash;

  always #5 clk = ~clk;

  seg_to_num #(.STABLE_CNT(SC)) dut (
    .clk(clk), .rst(rst), .sample(sample), .seg3(seg3), .seg2(seg2), .seg1(seg1),
    .num(num), .digit3(digit3), .digit2(digit2), .digit1(digit1), .valid(valid),
    .locked(locked), .err(err), .seq_err(seq_err), .dash(dash)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Index 0..9 are the digits, index 10 is the dash.
  logic [6:0]  pat_tbl [0:10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                                  7'b0111111};
  logic [11:0] step_tbl [0:6] = '{12'h000, 12'h003, 12'h032, 12'h321, 12'h210, 12'h100,
                                  12'hEEE};

  // Reference model state
  logic [20:0] m_trip;
  int          m_run, m_state, m_pstep;
  logic [31:0] m_num;
  logic [3:0]  m_d3, m_d2, m_d1;
  bit          m_valid, m_err, m_seq, m_dash;

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 11; i++)
      if (p == pat_tbl[i]) return (i == 10) ? 4'hE : 4'(i);
    return 4'hF;
  endfunction

  function automatic logic [20:0] trip_of(input logic [11:0] digs);
    logic [20:0] t;
    for (int k = 0; k < 3; k++) begin
      logic [3:0] nib;
      nib = digs[k*4 +: 4];
      t[k*7 +: 7] = (nib == 4'hE) ? pat_tbl[10] : pat_tbl[nib];
    end
    return t;
  endfunction

  task automatic model_clock(input bit r, input bit s, input logic [20:0] t);
    int k;
    m_err = 0;
    m_seq = 0;
    if (r) begin
      m_trip = '1; m_run = 0; m_state = 0; m_pstep = 0; m_num = 0;
      m_d3 = 0; m_d2 = 0; m_d1 = 0; m_valid = 0; m_dash = 0;
      return;
    end
    if (!s) return;
    m_run  = (t == m_trip) ? m_run + 1 : 1;
    m_trip = t;
    if (m_run != SC) return;
    m_d3 = ref_decode(t[20:14]);
    m_d2 = ref_decode(t[13:7]);
    m_d1 = ref_decode(t[6:0]);
    m_valid = 1;
    k = -1;
    for (int i = 0; i < 7; i++) if ({m_d3, m_d2, m_d1} == step_tbl[i]) k = i;
    if (k < 0) begin
      m_err = 1; m_state = 0; m_dash = 0;
    end else begin
      m_num  = k;
      m_dash = (k == 6);
      if (k == 6) begin
        if (m_state == 2) m_seq = 1;
        m_state = 0;
      end else begin
        if (m_state == 0) m_state = 1;
        else if (m_state == 1) begin
          if (k == (m_pstep + 1) % 6) m_state = 2;
        end else if (k != (m_pstep + 1) % 6) begin
          m_seq = 1; m_state = 1;
        end
        m_pstep = k;
      end
    end
  endtask

  task automatic tick(input bit r, input bit s, input logic [20:0] t);
    rst = r;
    sample = s;
    {seg3, seg2, seg1} = t;
    @(posedge clk);
    model_clock(r, s, t);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, trip_of(12'h321));
    n_checks++;
    if ({num, digit3, digit2, digit1, valid, locked, err, seq_err, dash} !== 49'd0)
      $display("FAIL reset: got num=%0d d=%h%h%h v=%b l=%b e=%b se=%b dash=%b, want all 0",
               num, digit3, digit2, digit1, valid, locked, err, seq_err, dash);
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [35:0] exp;
    tick(1, 0, '1);
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, trip_of(step_tbl[i]));
      tick(0, 1, trip_of(step_tbl[i]));
      exp = {32'(i), (i >= 1), 1'b0, 1'b0, 1'b1};
      n_checks++;
      if ({num, locked, err, seq_err, valid} !== exp)
        $display("FAIL sequence step %0d: got num=%0d l=%b e=%b se=%b v=%b, want %h",
                 i, num, locked, err, seq_err, valid, exp);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    tick(0, 1, trip_of(12'h000));
    tick(0, 1, trip_of(12'h000));
    n_checks++;
    if ({num, locked, seq_err} !== {32'd0, 1'b1, 1'b0})
      $display("FAIL wrap: got num=%0d l=%b se=%b, want 0 1 0", num, locked, seq_err);
    else n_pass++;
  endtask

  task automatic test_seq_err();
    tick(0, 1, trip_of(12'h003)); tick(0, 1, trip_of(12'h003));
    tick(0, 1, trip_of(12'h032)); tick(0, 1, trip_of(12'h032));
    tick(0, 1, trip_of(12'h210)); tick(0, 1, trip_of(12'h210));
    n_checks++;
    if ({num, locked, seq_err, err} !== {32'd4, 1'b0, 1'b1, 1'b0})
      $display("FAIL seq_err pulse: got num=%0d l=%b se=%b e=%b, want 4 0 1 0",
               num, locked, seq_err, err);
    else n_pass++;
    tick(0, 0, '1);
    n_checks++;
    if (seq_err !== 1'b0) $display("FAIL seq_err width: got %b want 0", seq_err);
    else n_pass++;
  endtask

  task automatic test_invalid();
    logic [20:0] t;
    t = {pat_tbl[0], pat_tbl[0], 7'b1111111};
    tick(0, 1, t); tick(0, 1, t);
    n_checks++;
    if ({err, seq_err, digit1, num, locked} !== {1'b1, 1'b0, 4'hF, 32'd4, 1'b0})
      $display("FAIL invalid: got e=%b se=%b d1=%h num=%0d l=%b, want 1 0 f 4 0",
               err, seq_err, digit1, num, locked);
    else n_pass++;
    tick(0, 1, t);
    n_checks++;
    if (err !== 1'b0) $display("FAIL invalid reaccept: got err=%b want 0", err);
    else n_pass++;
  endtask

  task automatic test_dash();
    tick(0, 1, trip_of(12'hEEE)); tick(0, 1, trip_of(12'hEEE));
    n_checks++;
    if ({num, dash, digit3, digit2, digit1, err} !== {32'd6, 1'b1, 12'hEEE, 1'b0})
      $display("FAIL dash: got num=%0d dash=%b d=%h%h%h e=%b, want 6 1 eee 0",
               num, dash, digit3, digit2, digit1, err);
    else n_pass++;
    for (int i = 0; i < 8; i++) tick(0, 1, trip_of((i % 2) ? 12'h003 : 12'h000));
    n_checks++;
    if ({num, dash, digit3, digit2, digit1} !== {32'd6, 1'b1, 12'hEEE})
      $display("FAIL alternate: got num=%0d dash=%b d=%h%h%h, want 6 1 eee",
               num, dash, digit3, digit2, digit1);
    else n_pass++;
  endtask

  task automatic test_hold();
    tick(0, 1, trip_of(12'h100));
    for (int i = 0; i < 3; i++) tick(0, 0, trip_of(12'h100));
    n_checks++;
    if (num !== 32'd6) $display("FAIL hold early: got num=%0d want 6", num);
    else n_pass++;
    tick(0, 1, trip_of(12'h100));
    n_checks++;
    if ({num, dash} !== {32'd5, 1'b0})
      $display("FAIL hold accept: got num=%0d dash=%b, want 5 0", num, dash);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick(0, 1, trip_of(12'h321));
    tick(1, 1, trip_of(12'h321));
    n_checks++;
    if ({num, digit3, digit2, digit1, valid, locked, err, seq_err, dash} !== 49'd0)
      $display("FAIL reset mid: got num=%0d d=%h%h%h v=%b l=%b, want all 0",
               num, digit3, digit2, digit1, valid, locked);
    else n_pass++;
    tick(0, 1, trip_of(12'h321));
    n_checks++;
    if (valid !== 1'b0) $display("FAIL reset mid early: got valid=%b want 0", valid);
    else n_pass++;
    tick(0, 1, trip_of(12'h321));
    n_checks++;
    if ({num, valid, digit3, digit2, digit1} !== {32'd3, 1'b1, 12'h321})
      $display("FAIL reset mid accept: got num=%0d v=%b d=%h%h%h, want 3 1 321",
               num, valid, digit3, digit2, digit1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [20:0] cur;
    logic [48:0] exp, got;
    bit r, s;
    int pick;
    cur = trip_of(12'h000);
    tick(1, 0, cur);
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 9);
      if (pick < 3) cur = trip_of(step_tbl[(m_pstep + 1) % 6]);
      else if (pick == 3) cur = trip_of(step_tbl[$urandom_range(0, 6)]);
      else if (pick == 4) cur = {pat_tbl[$urandom_range(0, 10)], pat_tbl[0], pat_tbl[3]};
      tick(r, s, cur);
      exp = {m_num, m_d3, m_d2, m_d1, m_valid, (m_state == 2), m_err, m_seq, m_dash};
      got = {num, digit3, digit2, digit1, valid, locked, err, seq_err, dash};
      n_checks++;
      if (got !== exp) $display("FAIL random cycle %0d: got %h want %h", n, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    model_clock(1, 0, '1);
    test_reset();
    test_sequence();
    test_wrap();
    test_seq_err();
    test_invalid();
    test_dash();
    test_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_to_num.md
SEG_TO_NUM -- requirements
Module: seg_to_num

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 2, the number of consecutive identical sampled triplets required before acceptance (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sample, input, 1, qualifies seg3/seg2/seg1 as a valid sample this cycle.
REQ-005 SHALL have ports seg3, seg2, seg1, input, 7 each, active-low segment patterns, bit6=g .. bit0=a; seg3 is the leftmost digit.
REQ-006 SHALL have port num, output, 32, recovered step index.
REQ-007 SHALL have ports digit3, digit2, digit1, output, 4 each, decoded digits.
REQ-008 SHALL have port valid, output, 1, set once any triplet has been accepted.
REQ-009 SHALL have port locked, output, 1, the sequence tracker is locked.
REQ-010 SHALL have port err, output, 1, one-cycle pulse for an undecodable accepted triplet.
REQ-011 SHALL have port seq_err, output, 1, one-cycle pulse for an out-of-order step while locked.
REQ-012 SHALL have port dash, output, 1, the last accepted triplet was all-dash.

Function
REQ-013 Per-digit decode SHALL be: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0111111=4'hE (dash); any other pattern=4'hF (invalid).
REQ-014 Step map SHALL be: 000->0, 003->1, 032->2, 321->3, 210->4, 100->5, all three digits dash->6; any other triplet SHALL be unmapped.
REQ-015 Stability filter: on each sample=1 cycle, if the triplet equals the previous sampled triplet, stab_cnt SHALL increment, saturating at 15; otherwise stab_cnt SHALL load 1.
REQ-016 The triplet SHALL be accepted exactly once, in the sample cycle where stab_cnt becomes equal to STABLE_CNT; further identical samples SHALL NOT re-accept.
REQ-017 Cycles with sample=0 SHALL leave the filter, FSM and held outputs unchanged.
REQ-018 On acceptance, digit3/2/1 SHALL register the decoded digits, valid SHALL go to 1, and the new values SHALL be visible one clock after the accepting edge.
REQ-019 Mapped acceptance SHALL update num to the mapped step (0..6) and set dash=1 only for step 6, else dash=0.
REQ-020 Unmapped acceptance SHALL leave num unchanged, pulse err for one cycle, and force the FSM to UNLOCKED.
REQ-021 FSM states: UNLOCKED, CANDIDATE, LOCKED.
REQ-022 UNLOCKED: an accepted step 0..5 SHALL move to CANDIDATE; step 6 SHALL stay UNLOCKED.
REQ-023 CANDIDATE: an accepted step equal to (prev+1) mod 6 SHALL move to LOCKED; any other mapped step SHALL stay CANDIDATE with the new step as prev; step 6 SHALL return to UNLOCKED.
REQ-024 LOCKED: an accepted step equal to (prev+1) mod 6 SHALL stay LOCKED, wrapping 5->0. Any other step, including 6, SHALL pulse seq_err and move to CANDIDATE with that step as prev, or to UNLOCKED if the step is 6.
REQ-025 locked SHALL equal 1 exactly while the FSM is in LOCKED.
REQ-026 err and seq_err SHALL never both be asserted in the same cycle, and each SHALL be high for at most one cycle per acceptance.

Reset
REQ-027 rst SHALL take priority over sample in the same cycle.
REQ-028 On reset: num=0, digit3/2/1=0, valid=0, locked=0, err=0, seq_err=0, dash=0, stab_cnt=0, FSM=UNLOCKED, previous-triplet register=all ones.
REQ-029 Reset asserted mid-filter or while LOCKED SHALL discard all progress; the next triplet SHALL require a full STABLE_CNT samples.

Verification
REQ-030 Reset, then triplet 000/003/032/321/210/100, each sampled 2 cycles -> num 0,1,2,3,4,5; locked=1 after the 003 acceptance; no err or seq_err.
REQ-031 Locked at step 5, then 000 sampled twice -> num=0, locked stays 1 (wrap accepted).
REQ-032 Locked at step 2, then 210 sampled twice -> seq_err pulse of 1 cycle, num=4, locked=0.
REQ-033 Triplet seg1=7'b1111111 sampled twice -> err pulse of 1 cycle, digit1=4'hF, num unchanged, locked=0.
REQ-034 Three dash digits (0111111) sampled twice -> num=6, dash=1, digits=E,E,E; alternate the triplet every sample -> no acceptance ever.
REQ-035 rst pulsed while sample=1 after one 321 sample -> all outputs at reset values; 321 needs 2 more samples to be accepted.
